// File: rtl/bar_cell_writer.sv
// Long-bar board writer: converts a landed bar's pixel reference to grid cells,
// bounds-checks it, then commits (or erases) its four cells through a ready/valid port.
module bar_cell_writer #(
  parameter int SIZE     = 16,
  parameter int BOARD_X0 = 240,
  parameter int BOARD_Y0 = 80,
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        ref_x,
  input  logic [9:0]        ref_y,
  input  logic              vertical,
  input  logic              erase,
  input  logic [2:0]        color,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  input  logic              wr_ready
);

  localparam int SHIFT = $clog2(SIZE);
  localparam int CW    = ADDR_W + 11;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [9:0]          x_reg, x_next;
  logic [9:0]          y_reg, y_next;
  logic                vert_reg, vert_next;
  logic [2:0]          data_reg, data_next;
  logic [1:0]          k_reg, k_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                err_reg, err_next;

  logic [9:0]          dx, dy;
  logic [CW-1:0]       col_w, row_w, base_w;
  logic                in_board, aligned, fits, req_valid;
  logic [ADDR_W-1:0]   step;

  // Offsets are only meaningful once in_board confirms no 10-bit wrap occurred.
  assign dx       = x_reg - 10'(BOARD_X0);
  assign dy       = y_reg - 10'(BOARD_Y0);
  assign col_w    = CW'(dx >> SHIFT);
  assign row_w    = CW'(dy >> SHIFT);
  assign base_w   = row_w * CW'(COLS) + col_w;
  assign in_board = (x_reg >= 10'(BOARD_X0)) && (y_reg >= 10'(BOARD_Y0));
  assign aligned  = ((dx & 10'(SIZE - 1)) == '0) && ((dy & 10'(SIZE - 1)) == '0);
  assign fits     = vert_reg ? ((col_w < CW'(COLS)) && (row_w + CW'(3) < CW'(ROWS)))
                             : ((col_w + CW'(3) < CW'(COLS)) && (row_w < CW'(ROWS)));
  assign req_valid = in_board && aligned && fits;
  assign step      = vert_reg ? ADDR_W'(COLS) : ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      vert_reg  <= 1'b0;
      data_reg  <= '0;
      k_reg     <= '0;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      vert_reg  <= vert_next;
      data_reg  <= data_next;
      k_reg     <= k_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    vert_next  = vert_reg;
    data_next  = data_reg;
    k_next     = k_reg;
    addr_next  = addr_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = ref_x;
          y_next     = ref_y;
          vert_next  = vertical;
          data_next  = erase ? 3'd0 : color;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (req_valid) begin
          addr_next  = ADDR_W'(base_w);
          k_next     = '0;
          state_next = WRITE;
        end else begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        // Address/data only advance on accept, so they hold through stalls.
        if (wr_ready) begin
          addr_next = addr_reg + step;
          k_next    = k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            k_next     = '0;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign wr_en   = (state_reg == WRITE);
  assign err     = err_reg;
  assign wr_addr = addr_reg;
  assign wr_data = data_reg;

endmodule

// File: tb/tb_bar_cell_writer.sv
// Self-checking bench for bar_cell_writer: a grid-level reference model feeds a
// write scoreboard checked every cycle, plus directed timing checks per request.
module tb_bar_cell_writer;

  localparam int SZ     = 16;
  localparam int BX0    = 240;
  localparam int BY0    = 80;
  localparam int NCOLS  = 10;
  localparam int NROWS  = 20;
  localparam int AW     = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [9:0]    ref_x, ref_y;
  logic          vertical, erase;
  logic [2:0]    color;
  logic          busy, done, err, wr_en, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  bar_cell_writer #(
    .SIZE(SZ), .BOARD_X0(BX0), .BOARD_Y0(BY0), .COLS(NCOLS), .ROWS(NROWS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ref_x(ref_x), .ref_y(ref_y),
    .vertical(vertical), .erase(erase), .color(color), .busy(busy), .done(done),
    .err(err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_addr[$];
  int exp_data[$];
  int pat[8];
  int npat = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Grid-level model: address of cell k for a bar, or -1 if the bar is rejected.
  function automatic int model_addr(input int x, input int y, input bit v, input int k);
    int col, row;
    if (x < BX0 || y < BY0) return -1;
    if ((x - BX0) % SZ != 0 || (y - BY0) % SZ != 0) return -1;
    col = (x - BX0) / SZ;
    row = (y - BY0) / SZ;
    if (v ? (col >= NCOLS || row + 4 > NROWS) : (col + 4 > NCOLS || row >= NROWS)) return -1;
    return v ? (row + k) * NCOLS + col : row * NCOLS + col + k;
  endfunction

  task automatic model_push(input int x, input int y, input bit v, input int d);
    if (model_addr(x, y, v, 0) >= 0) begin
      for (int k = 0; k < 4; k++) begin
        exp_addr.push_back(model_addr(x, y, v, k));
        exp_data.push_back(d);
      end
    end
  endtask

  // Per-cycle compare process: accepted writes vs model, stall stability, pulse rules.
  logic          prev_stall = 1'b0;
  logic          prev_done  = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [2:0]    prev_data  = '0;

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_wr_en_held", int'(wr_en), 1);
      chk("stall_addr_held", int'(wr_addr), int'(prev_addr));
      chk("stall_data_held", int'(wr_data), int'(prev_data));
    end
    if (wr_en === 1'b1 && wr_ready === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=%0d expected=no_write", wr_addr);
      end else begin
        chk("wr_addr", int'(wr_addr), exp_addr.pop_front());
        chk("wr_data", int'(wr_data), exp_data.pop_front());
      end
    end
    if (done === 1'b1) chk("done_err_exclusive", int'(err), 0);
    if (prev_done) chk("done_one_cycle", int'(done), 0);
    prev_stall = (wr_en === 1'b1) && (wr_ready === 1'b0) && (reset === 1'b0);
    prev_done  = (done === 1'b1) && (reset === 1'b0);
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  // Issues one request from IDLE (called at posedge+1) and records its timeline.
  task automatic run_req(input int x, input int y, input bit v, input bit e, input int c,
                         output int r_done, output int r_err, output int r_acc,
                         output int r_last, output int r_first, output int r_busy_n,
                         output int r_busy_after);
    bit fin;
    r_done = -1; r_err = -1; r_acc = 0; r_last = -1; r_first = -1;
    r_busy_n = 0; r_busy_after = -1; fin = 0;
    ref_x = 10'(x); ref_y = 10'(y); vertical = v; erase = e; color = 3'(c);
    start = 1'b1;
    wr_ready = 1'b1;
    model_push(x, y, v, e ? 0 : c);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      wr_ready = (cyc >= 2 && cyc - 2 < npat) ? 1'(pat[cyc-2]) : 1'b1;
      @(negedge clk);
      if (busy) r_busy_n++;
      if (wr_en) begin
        if (r_first < 0) r_first = cyc;
        if (wr_ready) begin
          r_acc++;
          r_last = cyc;
        end
      end
      if (done && r_done < 0) r_done = cyc;
      if (err && r_err < 0) r_err = cyc;
      if ((r_done >= 0 && cyc == r_done + 1) || (r_err >= 0 && cyc == r_err)) begin
        r_busy_after = int'(busy);
        fin = 1;
      end
      @(posedge clk); #1;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL request_timeout actual=no_done_or_err expected=finish_within_40");
    end
    wr_ready = 1'b1;
  endtask

  task automatic check_req(input string name, input int x, input int y, input bit v,
                           input bit e, input int c);
    int d, r, a, l, f, bn, ba;
    run_req(x, y, v, e, c, d, r, a, l, f, bn, ba);
    if (model_addr(x, y, v, 0) >= 0) begin
      chk({name, "_accepts"}, a, 4);
      chk({name, "_first_write_cycle"}, f, 2);
      chk({name, "_done_after_last"}, d, l + 1);
      chk({name, "_err"}, r, -1);
      chk({name, "_busy_cycles"}, bn, d);
      chk({name, "_busy_after_done"}, ba, 0);
      chk({name, "_queue_drained"}, exp_addr.size(), 0);
    end else begin
      chk({name, "_err_cycle"}, r, 2);
      chk({name, "_no_writes"}, f, -1);
      chk({name, "_no_done"}, d, -1);
      chk({name, "_busy_cycles"}, bn, 1);
      chk({name, "_busy_at_err"}, ba, 0);
    end
    $display("txn %s ref=(%0d,%0d) v=%0d e=%0d c=%0d done=%0d err=%0d accepts=%0d",
             name, x, y, v, e, c, d, r, a);
  endtask

  initial begin
    int d, r, a, l, f, bn, ba;
    int done1, done2, busy7, busy8, wr_seen;
    reset = 1'b1; start = 1'b0; ref_x = '0; ref_y = '0;
    vertical = 1'b0; erase = 1'b0; color = '0; wr_ready = 1'b0;

    // Hand-computed pins on the model itself
    chk("model_h_first", model_addr(240, 80, 0, 0), 0);
    chk("model_h_last", model_addr(240, 80, 0, 3), 3);
    chk("model_v_first", model_addr(384, 336, 1, 0), 169);
    chk("model_v_last", model_addr(384, 336, 1, 3), 199);
    chk("model_rej_right", model_addr(352, 80, 0, 0), -1);
    chk("model_rej_misalign", model_addr(241, 80, 0, 0), -1);
    chk("model_rej_left", model_addr(224, 80, 0, 0), -1);
    chk("model_rej_bottom", model_addr(240, 352, 1, 0), -1);

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_ready = 1'b1;

    // Back-to-back horizontal write with literal timeline
    run_req(240, 80, 0, 0, 5, d, r, a, l, f, bn, ba);
    chk("h0_done_cycle", d, 6);
    chk("h0_first_write", f, 2);
    chk("h0_last_write", l, 5);
    chk("h0_busy_cycles", bn, 6);
    chk("h0_busy_cycle7", ba, 0);
    chk("h0_accepts", a, 4);
    $display("txn h0 ref=(240,80) done=%0d accepts=%0d", d, a);

    check_req("v_erase", 384, 336, 1, 1, 6);
    check_req("h_color0", 336, 384, 0, 0, 0);
    check_req("rej_right", 352, 80, 0, 0, 3);
    check_req("rej_misalign", 241, 80, 0, 0, 3);
    check_req("rej_left", 224, 80, 0, 0, 3);
    check_req("rej_bottom", 240, 352, 1, 0, 3);

    // Stalled vertical write: accepts land in cycles 4,6,7,8
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1; pat[5] = 1; pat[6] = 1;
    npat = 7;
    run_req(320, 80, 1, 0, 7, d, r, a, l, f, bn, ba);
    npat = 0;
    chk("stall_accepts", a, 4);
    chk("stall_last_accept", l, 8);
    chk("stall_done_cycle", d, 9);
    chk("stall_queue_drained", exp_addr.size(), 0);
    $display("txn stall ref=(320,80) done=%0d accepts=%0d", d, a);

    // Reset after two accepted writes (cells 52,53 written; 54,55 abandoned)
    ref_x = 10'(272); ref_y = 10'(160); vertical = 1'b0; erase = 1'b0; color = 3'd4;
    model_push(272, 160, 0, 4);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_pre_wr_en", int'(wr_en), 1);
    chk("rst_pre_addr", int'(wr_addr), model_addr(272, 160, 0, 2));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_remaining", exp_addr.size(), 2);
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    wr_ready = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_en || done || busy) wr_seen++;
    end
    chk("rst_stays_idle", wr_seen, 0);
    $display("txn reset_mid ref=(272,160) idle_activity=%0d", wr_seen);
    @(posedge clk); #1;

    // start held through CHECK/WRITE/DONE with another ref; accepted again in cycle 7
    ref_x = 10'(288); ref_y = 10'(240); vertical = 1'b0; erase = 1'b0; color = 3'd6;
    model_push(288, 240, 0, 6);
    model_push(240, 112, 1, 1);
    start = 1'b1;
    @(posedge clk); #1;
    ref_x = 10'(240); ref_y = 10'(112); vertical = 1'b1; color = 3'd1;
    done1 = -1; done2 = -1; busy7 = -1; busy8 = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 8) start = 1'b0;
      @(negedge clk);
      if (cyc == 7) busy7 = int'(busy);
      if (cyc == 8) busy8 = int'(busy);
      if (done) begin
        if (done1 < 0) done1 = cyc;
        else if (done2 < 0) done2 = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ign_first_done", done1, 6);
    chk("ign_busy_cycle7", busy7, 0);
    chk("ign_busy_cycle8", busy8, 1);
    chk("ign_second_done", done2, 13);
    chk("ign_queue_drained", exp_addr.size(), 0);
    $display("txn start_ignored done1=%0d done2=%0d", done1, done2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bar_cell_writer.md
# bar_cell_writer

Board-side write engine for the long bar. When a falling long bar lands, the game logic hands this block the bar's pixel reference position (the same `ref_x`/`ref_y` the renderer draws from), its orientation and colour. The block converts the position to playfield grid coordinates, bounds-checks it, and commits the four cells into the board cell RAM through a ready/valid write port. An erase mode clears the same four cells. It sits between the piece controller and the board RAM that the playfield renderer reads.

## Interface
Parameters:
- `SIZE`, 16: block edge in pixels; must be a power of two.
- `BOARD_X0`, 240: pixel x of board column 0.
- `BOARD_Y0`, 80: pixel y of board row 0.
- `COLS`, 10: board columns.
- `ROWS`, 20: board rows.
- `ADDR_W`, 8: board RAM address width; must satisfy `COLS*ROWS <= 2**ADDR_W`.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `ref_x`, `ref_y`  in  10 each  pixel position of the bar's first (top/left) cell.
- `vertical`  in  1  0 = horizontal (cells along x), 1 = vertical (cells along y).
- `erase`  in  1  1 = write 0 to all four cells; colour ignored.
- `color`  in  3  cell value to write; 0 means empty.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse after the fourth write is accepted.
- `err`  out  1  one-cycle pulse when a request is rejected; no writes are issued.
- `wr_en`  out  1  write request valid.
- `wr_addr`  out  ADDR_W  cell address, `row*COLS + col`.
- `wr_data`  out  3  cell value.
- `wr_ready`  in  1  RAM accepts the write when `wr_en && wr_ready`.

## Operation
- FSM states: IDLE, CHECK, WRITE, DONE.
- IDLE → CHECK when `start=1`. All request inputs are latched in this same cycle. Later input changes have no effect.
- CHECK, one cycle. A request is valid only if all of the following hold:
  - `ref_x >= BOARD_X0` and `ref_y >= BOARD_Y0`, tested before subtracting.
  - `(ref_x-BOARD_X0)` and `(ref_y-BOARD_Y0)` are multiples of `SIZE`.
  - Horizontal: `col+3 < COLS` and `row < ROWS`.
  - Vertical: `col < COLS` and `row+3 < ROWS`.
  - Here `col = (ref_x-BOARD_X0) >> log2(SIZE)` and `row = (ref_y-BOARD_Y0) >> log2(SIZE)`.
  - Valid → WRITE with base address `row*COLS+col` and cell index k=0.
  - Invalid → `err` pulse and return to IDLE.
- WRITE:
  - Drive `wr_en=1`.
  - `wr_addr` = base+k (horizontal) or base+k*COLS (vertical).
  - `wr_data` = `erase ? 0 : color`.
  - On the accept cycle, k increments. Accepting k=3 moves to DONE.
- DONE, one cycle: `done=1`, then IDLE.
- `start` is ignored in CHECK, WRITE and DONE. It is not queued.
- Address arithmetic is at least ADDR_W+1 bits wide, with no truncation for legal parameters. Subtraction is 10-bit.
- `color=0` with `erase=0` is legal and writes 0.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, state IDLE, k=0.
- Reset asserted mid-operation: on the next edge all outputs return to their reset values. Remaining writes are abandoned and cells already accepted stay written. No `done` or `err` is produced.
- With `wr_ready` held at 1, relative to start accepted at edge 0:
  - CHECK in cycle 1.
  - Writes in cycles 2–5, one per cycle, back-to-back.
  - `done` in cycle 6.
  - `busy` low in cycle 7, which is the earliest cycle a new `start` is accepted.
- Reject path: `err` is high in cycle 2, `busy` is high in cycle 1 only, IDLE in cycle 2. A new `start` is accepted in cycle 2.
- Stall: while `wr_en=1` and `wr_ready=0`, `wr_addr` and `wr_data` hold stable. `wr_en` never drops without an accept, except on reset.
- `done` and `err` never assert in the same cycle. Each is exactly one cycle wide.

## Test plan
- Horizontal, `ref=(240,80)`, `color=5`, `wr_ready=1`: addresses 0,1,2,3 with data 5 in cycles 2–5; `done` in cycle 6; `busy` cycles 1–6.
- Vertical erase, `ref=(384,336)`, `erase=1`: col 9, row 16; addresses 169,179,189,199 with data 0; `done` asserted.
- Rejects, no `wr_en` in any case, `err` in cycle 2:
  - horizontal `ref_x=352` (col 7+3 = 10);
  - `ref_x=241` (misaligned);
  - `ref_x=224` (left of board);
  - vertical `ref_y=352` (row 17+3 = 20).
- Stall: `wr_ready` pattern 0,0,1,0,1,1,1 during WRITE. Address and data hold across the stalls; exactly four accepts; `done` one cycle after the last accept.
- Reset after two accepted writes: `wr_en`, `busy` and `done` are 0 from the next cycle. Addresses 2 and 3 are never written.
- `start` pulsed in the CHECK, WRITE and DONE cycles with a different `ref` is ignored; the original four addresses are written. `start` in cycle 7 is accepted.
